// File: rtl/dp_pkg.sv
// Shared definitions for the datapath micro-sequencer: instruction word layout,
// datapath field widths and the sequencer state encoding.
package dp_pkg;

  localparam int INSTR_W  = 10;
  localparam int REG_AW   = 2;
  localparam int ALU_CW   = 3;

  localparam int HALT_BIT = 9;
  localparam int OP_MSB   = 8;
  localparam int OP_LSB   = 6;
  localparam int A3_MSB   = 5;
  localparam int A3_LSB   = 4;
  localparam int A1_MSB   = 3;
  localparam int A1_LSB   = 2;
  localparam int A2_MSB   = 1;
  localparam int A2_LSB   = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic              halt;
    logic [ALU_CW-1:0] op;
    logic [REG_AW-1:0] a3;
    logic [REG_AW-1:0] a1;
    logic [REG_AW-1:0] a2;
  } instr_t;

  // Split a raw program word into its named fields.
  function automatic instr_t decode(input logic [INSTR_W-1:0] word);
    instr_t f;
    f.halt = word[HALT_BIT];
    f.op   = word[OP_MSB:OP_LSB];
    f.a3   = word[A3_MSB:A3_LSB];
    f.a1   = word[A1_MSB:A1_LSB];
    f.a2   = word[A2_MSB:A2_LSB];
    return f;
  endfunction

endpackage

// File: rtl/dp_sequencer_if.sv
// Control, program-load and datapath-drive bundle of the micro-sequencer.
// The master side (software/testbench) drives control and load; the sequencer is the slave.
interface dp_sequencer_if import dp_pkg::*; #(
  parameter int AW = 4
);

  logic               start;
  logic               abort;
  logic               hold;
  logic               load_en;
  logic [AW-1:0]      load_addr;
  logic [INSTR_W-1:0] load_data;
  logic               busy;
  logic               done;
  logic               wr;
  logic [REG_AW-1:0]  addr1;
  logic [REG_AW-1:0]  addr2;
  logic [REG_AW-1:0]  addr3;
  logic [ALU_CW-1:0]  ALUControl;
  logic [AW:0]        exec_count;

  modport master (
    output start, abort, hold, load_en, load_addr, load_data,
    input  busy, done, wr, addr1, addr2, addr3, ALUControl, exec_count
  );

  modport slave (
    input  start, abort, hold, load_en, load_addr, load_data,
    output busy, done, wr, addr1, addr2, addr3, ALUControl, exec_count
  );

endinterface

// File: rtl/dp_prog_store.sv
// Program store: DEPTH instruction words, one synchronous write port and one
// asynchronous read port so the sequencer decodes the current word in the same cycle.
module dp_prog_store import dp_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic [AW-1:0]      rd_addr,
  output logic [INSTR_W-1:0] rd_data
);

  logic [INSTR_W-1:0] mem_r [DEPTH];

  // Contents are deliberately not reset so a loaded program survives rst.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/dp_sequencer.sv
// Micro-sequencer issuing one register-to-register ALU operation per cycle from the
// program store until a halt word or the end of the store.
module dp_sequencer import dp_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  dp_sequencer_if.slave bus
);

  state_e             state_r, state_nxt_s;
  logic [AW-1:0]      pc_r, pc_nxt_s;
  logic [AW:0]        exec_count_r, exec_count_nxt_s;
  logic [INSTR_W-1:0] word_s;
  instr_t             instr_s;
  logic               load_ok_s;
  logic               wr_s;
  logic [REG_AW-1:0]  addr1_s, addr2_s, addr3_s;
  logic [ALU_CW-1:0]  alu_s;

  // Loads are accepted only while idle; a load in the start cycle lands before word 0 is read.
  assign load_ok_s = bus.load_en && (state_r == IDLE);

  dp_prog_store #(.DEPTH(DEPTH), .AW(AW)) u_store (
    .clk     (clk),
    .wr_en   (load_ok_s),
    .wr_addr (bus.load_addr),
    .wr_data (bus.load_data),
    .rd_addr (pc_r),
    .rd_data (word_s)
  );

  assign instr_s = decode(word_s);

  // State, program counter and issue counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      pc_r         <= {AW{1'b0}};
      exec_count_r <= {(AW+1){1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      pc_r         <= pc_nxt_s;
      exec_count_r <= exec_count_nxt_s;
    end
  end

  // Next-state and datapath drive; abort outranks hold, halt and start.
  always_comb begin
    state_nxt_s      = state_r;
    pc_nxt_s         = pc_r;
    exec_count_nxt_s = exec_count_r;
    wr_s             = 1'b0;
    addr1_s          = {REG_AW{1'b0}};
    addr2_s          = {REG_AW{1'b0}};
    addr3_s          = {REG_AW{1'b0}};
    alu_s            = {ALU_CW{1'b0}};
    if (bus.abort) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            state_nxt_s      = EXEC;
            pc_nxt_s         = {AW{1'b0}};
            exec_count_nxt_s = {(AW+1){1'b0}};
          end else begin
            state_nxt_s = IDLE;
          end
        end
        EXEC: begin
          if (instr_s.halt) begin
            state_nxt_s = DONE;
          end else begin
            addr1_s = instr_s.a1;
            addr2_s = instr_s.a2;
            addr3_s = instr_s.a3;
            alu_s   = instr_s.op;
            if (bus.hold) begin
              state_nxt_s = EXEC;
            end else begin
              wr_s             = 1'b1;
              pc_nxt_s         = pc_r + AW'(1);
              exec_count_nxt_s = exec_count_r + (AW+1)'(1);
              // The last word has just issued; pc wraps naturally to 0.
              if (pc_r == AW'(DEPTH - 1)) begin
                state_nxt_s = DONE;
              end else begin
                state_nxt_s = EXEC;
              end
            end
          end
        end
        DONE: begin
          state_nxt_s = IDLE;
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = (state_r == EXEC);
  assign bus.done       = (state_r == DONE);
  assign bus.wr         = wr_s;
  assign bus.addr1      = addr1_s;
  assign bus.addr2      = addr2_s;
  assign bus.addr3      = addr3_s;
  assign bus.ALUControl = alu_s;
  assign bus.exec_count = exec_count_r;

endmodule

// File: tb/tb_dp_sequencer.sv
// Directed bench for dp_sequencer with a behavioural 4 x 32-bit register file and ALU
// attached to the datapath-drive outputs.
module tb_dp_sequencer;
  import dp_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rf_load = 1'b0;
  logic [31:0] rf [4];
  int          checks = 0;
  int          failures = 0;

  dp_sequencer_if #(.AW(4)) bus ();

  dp_sequencer #(.DEPTH(16), .AW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] op);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Register-file model captures the ALU result on the edge that ends a wr cycle.
  always @(posedge clk) begin
    if (rf_load) begin
      rf[0] <= 32'd5;
      rf[1] <= 32'd7;
      rf[2] <= 32'd10;
      rf[3] <= 32'd3;
    end else if (bus.wr) begin
      rf[bus.addr3] <= alu(rf[bus.addr1], rf[bus.addr2], bus.ALUControl);
    end
  end

  function automatic logic [31:0] outs();
    return {20'd0, bus.busy, bus.done, bus.wr, bus.addr1, bus.addr2, bus.addr3, bus.ALUControl};
  endfunction

  function automatic logic [31:0] ev(input logic b, input logic d, input logic w,
                                     input logic [1:0] a1, input logic [1:0] a2,
                                     input logic [1:0] a3, input logic [2:0] op);
    return {20'd0, b, d, w, a1, a2, a3, op};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [9:0] d);
    bus.load_en   = 1'b1;
    bus.load_addr = a;
    bus.load_data = d;
    cycle();
    bus.load_en   = 1'b0;
  endtask

  task automatic load_prog3();
    load(4'd0, 10'b0_010_01_10_11);
    load(4'd1, 10'b0_110_10_01_01);
    load(4'd2, 10'b0_000_11_10_01);
    load(4'd3, 10'b1_000_00_00_00);
  endtask

  initial begin
    logic [3:0] k;
    bus.start = 1'b0; bus.abort = 1'b0; bus.hold = 1'b0;
    bus.load_en = 1'b0; bus.load_addr = 4'd0; bus.load_data = 10'd0;

    // Reset then idle
    cycle(); cycle();
    rst = 1'b0;
    repeat (5) cycle();
    chk("reset_outs", outs(), 32'd0);
    chk("reset_cnt", 32'(bus.exec_count), 32'd0);

    // Three-op program ending in halt
    load_prog3();
    rf_load = 1'b1; cycle(); rf_load = 1'b0;
    bus.start = 1'b1; cycle(); bus.start = 1'b0;
    chk("run_w0", outs(), ev(1'b1, 1'b0, 1'b1, 2'd2, 2'd3, 2'd1, 3'd2));
    cycle();
    chk("run_w1", outs(), ev(1'b1, 1'b0, 1'b1, 2'd1, 2'd1, 2'd2, 3'd6));
    cycle();
    chk("run_w2", outs(), ev(1'b1, 1'b0, 1'b1, 2'd2, 2'd1, 2'd3, 3'd0));
    cycle();
    chk("run_halt", outs(), ev(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0));
    cycle();
    chk("run_done", outs(), ev(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0));
    chk("run_cnt", 32'(bus.exec_count), 32'd3);
    cycle();
    chk("run_idle", outs(), 32'd0);
    chk("run_cnt_hold", 32'(bus.exec_count), 32'd3);
    chk("rf_r0", rf[0], 32'd5);
    chk("rf_r1", rf[1], 32'd13);
    chk("rf_r2", rf[2], 32'd0);
    chk("rf_r3", rf[3], 32'd0);

    // Same program with two hold cycles on word 1
    bus.start = 1'b1; cycle(); bus.start = 1'b0;
    chk("hold_w0", outs(), ev(1'b1, 1'b0, 1'b1, 2'd2, 2'd3, 2'd1, 3'd2));
    cycle();
    bus.hold = 1'b1; #1;
    chk("hold_c1", outs(), ev(1'b1, 1'b0, 1'b0, 2'd1, 2'd1, 2'd2, 3'd6));
    cycle();
    chk("hold_c2", outs(), ev(1'b1, 1'b0, 1'b0, 2'd1, 2'd1, 2'd2, 3'd6));
    bus.hold = 1'b0; #1;
    chk("hold_w1", outs(), ev(1'b1, 1'b0, 1'b1, 2'd1, 2'd1, 2'd2, 3'd6));
    cycle();
    chk("hold_w2", outs(), ev(1'b1, 1'b0, 1'b1, 2'd2, 2'd1, 2'd3, 3'd0));
    cycle(); cycle();
    chk("hold_done", outs(), ev(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0));
    chk("hold_cnt", 32'(bus.exec_count), 32'd3);
    cycle();

    // Full store with no halt word
    for (int i = 0; i < 16; i++) begin
      k = 4'(i);
      load(k, {1'b0, k[2:0], k[1:0], k[3:2], ~k[1:0]});
    end
    bus.start = 1'b1; cycle(); bus.start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      k = 4'(i);
      chk($sformatf("full_w%0d", i), outs(),
          ev(1'b1, 1'b0, 1'b1, k[3:2], ~k[1:0], k[1:0], k[2:0]));
      cycle();
    end
    chk("full_done", outs(), ev(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0));
    chk("full_cnt", 32'(bus.exec_count), 32'd16);
    cycle();
    chk("full_idle", outs(), 32'd0);

    // Abort on the second EXEC cycle, with a load attempted while busy
    load_prog3();
    bus.start = 1'b1; cycle(); bus.start = 1'b0;
    bus.load_en = 1'b1; bus.load_addr = 4'd0; bus.load_data = 10'b1_000_00_00_00;
    cycle();
    bus.load_en = 1'b0;
    bus.abort = 1'b1; #1;
    chk("abort_wr", 32'(bus.wr), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd1);
    cycle();
    bus.abort = 1'b0;
    chk("abort_idle", outs(), 32'd0);
    chk("abort_cnt", 32'(bus.exec_count), 32'd1);
    cycle();
    chk("abort_nodone", outs(), 32'd0);
    bus.start = 1'b1; cycle(); bus.start = 1'b0;
    chk("store_kept", outs(), ev(1'b1, 1'b0, 1'b1, 2'd2, 2'd3, 2'd1, 3'd2));
    bus.abort = 1'b1; cycle(); bus.abort = 1'b0;

    // Reset mid-run together with start
    bus.start = 1'b1; cycle(); bus.start = 1'b0;
    cycle();
    rst = 1'b1; bus.start = 1'b1;
    cycle();
    chk("rst_outs", outs(), 32'd0);
    chk("rst_cnt", 32'(bus.exec_count), 32'd0);
    rst = 1'b0;
    cycle();
    bus.start = 1'b0;
    chk("rst_restart", outs(), ev(1'b1, 1'b0, 1'b1, 2'd2, 2'd3, 2'd1, 3'd2));
    cycle(); cycle(); cycle(); cycle();
    chk("rst_done", outs(), ev(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0));
    chk("rst_run_cnt", 32'(bus.exec_count), 32'd3);
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dp_sequencer.md
Name: dp_sequencer

Overview:
Micro-sequencer that drives the register-file/ALU datapath (4 x 32-bit registers, 2-bit addresses, 3-bit ALUControl) from a small loadable program store. Software or a testbench loads instruction words, pulses start, and the block issues one register-to-register ALU operation per cycle until a halt word or the end of the store. It sits directly above the datapath and owns its wr, addr1/addr2/addr3 and ALUControl inputs.

Parameters:
DEPTH, 16, number of program words (power of two, 2..256)
AW, 4, program address width = log2(DEPTH)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin execution at word 0; sampled only in IDLE
abort  input  1  terminate execution; return to IDLE next cycle
hold  input  1  stall: freeze pc, suppress wr
load_en  input  1  write load_data into program store at load_addr
load_addr  input  AW  program store write address
load_data  input  10  instruction word {halt[9], op[8:6], a3[5:4], a1[3:2], a2[1:0]}
busy  output  1  high in EXEC
done  output  1  one-cycle pulse on completion (halt or end of store)
wr  output  1  datapath register-file write enable
addr1  output  2  datapath read port 1 address (ALU A)
addr2  output  2  datapath read port 2 address (ALU B)
addr3  output  2  datapath write address
ALUControl  output  3  datapath ALU operation, passed through from op unmodified
exec_count  output  AW+1  instructions issued with wr=1 in current/last run

Behaviour:
- Reset: state IDLE, pc=0, exec_count=0, busy=0, done=0, wr=0, addr1/2/3=0, ALUControl=0. Program store contents are not reset.
- States: IDLE, EXEC, DONE.
- IDLE: outputs zero. start=1 -> EXEC, pc=0, exec_count=0. start and load_en in the same cycle: the load is performed and execution starts; word 0 written this cycle is used.
- EXEC: fields decoded combinationally from store[pc], no extra register stage. If current word halt=1: wr=0, addr/ALUControl=0, -> DONE, pc unchanged. Else if hold=1: wr=0, address/ALUControl still driven from current word, pc unchanged. Else wr=1, fields driven, exec_count+1, pc+1 at edge; the regfile captures the ALU result on that same edge.
- Latency: start sampled at edge N -> first wr=1 cycle is N..N+1; a program of K non-halt words followed by halt gives K wr cycles, done high on cycle K+1 after the halt cycle, with no holds.
- End of store: issuing word DEPTH-1 (non-halt) -> DONE next cycle, pc wraps to 0; no word re-executed.
- DONE: done=1 for exactly one cycle, busy=0, wr=0 -> IDLE. exec_count holds until next start.
- abort (any state): priority over hold/halt/start; wr=0 that cycle; -> IDLE next edge, no done pulse; exec_count retains issued count.
- rst: priority over everything incl. abort; mid-run reset yields reset values next edge; partially executed regfile writes stand.
- load_en while busy=1 or in DONE: ignored (store unchanged).
- start in EXEC/DONE: ignored. hold in IDLE/DONE: no effect.
- Dependent instructions need no interlock: the regfile write completes on the edge, and the next word reads the new value.

Decomposition:
- Shared package dp_pkg: instruction field positions/widths (HALT_BIT, OP_MSB/LSB, A3/A1/A2 slices), INSTR_W=10, REG_AW=2, ALU_CW=3, state enum {IDLE, EXEC, DONE}.
- One sub-module natural: dp_prog_store (DEPTH x 10 register array, one sync write port, one async read port).
- Top of test system: dp_sequencer + existing datapath, wired port-for-port.

Test Plan:
- Reset then idle 5 cycles -> busy=0, done=0, wr=0, all addresses/ALUControl=0, exec_count=0.
- Load 3 ops (op=2 a3=1 a1=2 a2=3; op=6 a3=2 a1=1 a2=1; op=0 a3=3 a1=2 a2=1) + halt at word 3, pulse start -> wr=1 for exactly 3 consecutive cycles with those fields in order; done pulse 1 cycle after the halt cycle; exec_count=3. Check regfile against model.
- Same program, hold=1 for 2 cycles during word 1 -> wr low 2 cycles with addr1=1, addr2=1, addr3=2 held; total run 2 cycles longer; exec_count=3.
- DEPTH=16, no halt words -> 16 wr cycles, pc wraps, done after word 15, exec_count=16.
- abort asserted on 2nd EXEC cycle -> wr=0 that cycle, IDLE next, no done pulse, exec_count=1; load_en during EXEC leaves store unchanged (readback via rerun).
- rst asserted mid-run together with start -> all outputs at reset values next cycle; start then honoured after rst drops.
